// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types: the 32-bit data word and the RISC-MGMT memory bridge state encoding.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RMGMT_IDLE     = 2'd0,
    RMGMT_WAIT_BUS = 2'd1,
    RMGMT_ACCESS   = 2'd2,
    RMGMT_DONE     = 2'd3
  } rmgmt_mem_state_t;

  localparam logic [3:0] DBUS_BYTE_EN_WORD = 4'b1111;

endpackage

// File: rtl/rmgmt_mem_bridge.sv
// Arbitrates RISC-MGMT extension memory requests onto the shared data bus, yielding to the core.
// Optional misaligned-access trap: define RMGMT_MEM_ALIGN_CHK_EN.
module rmgmt_mem_bridge
  import rv32i_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_mem,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  word_t       mem_addr,
  input  word_t       mem_store,
  output word_t       mem_load,
  output logic        mem_busy,
  input  logic        core_dreq,
  input  logic        flush,
  output word_t       dbus_addr,
  output word_t       dbus_wdata,
  output logic        dbus_ren,
  output logic        dbus_wen,
  output logic [3:0]  dbus_byte_en,
  input  logic        dbus_busy,
  input  word_t       dbus_rdata,
  output logic        mem_fault
);

  rmgmt_mem_state_t state_q, state_d;
  word_t            addr_q, addr_d;
  word_t            wdata_q, wdata_d;
  logic             wr_q, wr_d;
  word_t            load_q, load_d;
  logic             misaligned;
  logic             req_valid;
  logic             in_access;
  word_t            addr_out;

`ifdef RMGMT_MEM_ALIGN_CHK_EN
  logic fault_q, fault_d;
  assign misaligned = |mem_addr[1:0];
  assign addr_out   = addr_q;
  assign mem_fault  = fault_q;
`else
  assign misaligned = 1'b0;
  // Word-only bus: low address bits are dropped rather than trapped.
  assign addr_out   = addr_q & 32'hFFFF_FFFC;
  assign mem_fault  = 1'b0;
`endif

  assign req_valid = req_mem && (mem_ren || mem_wen) && !flush;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    load_d  = load_q;
`ifdef RMGMT_MEM_ALIGN_CHK_EN
    fault_d = 1'b0;
`endif
    case (state_q)
      RMGMT_IDLE: begin
        if (req_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_store;
          // Both strobes high resolves to a write.
          wr_d    = mem_wen;
          if (misaligned) begin
`ifdef RMGMT_MEM_ALIGN_CHK_EN
            fault_d = 1'b1;
`endif
            state_d = RMGMT_DONE;
          end else if (core_dreq) begin
            state_d = RMGMT_WAIT_BUS;
          end else begin
            state_d = RMGMT_ACCESS;
          end
        end
      end
      RMGMT_WAIT_BUS: begin
        if (flush || !req_mem) begin
          state_d = RMGMT_IDLE;
        end else if (!core_dreq) begin
          state_d = RMGMT_ACCESS;
        end
      end
      RMGMT_ACCESS: begin
        // Once on the bus the access always completes; flush and req_mem are ignored.
        if (!dbus_busy) begin
          if (!wr_q) begin
            load_d = dbus_rdata;
          end
          state_d = RMGMT_DONE;
        end
      end
      RMGMT_DONE: begin
        state_d = RMGMT_IDLE;
      end
      default: begin
        state_d = RMGMT_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RMGMT_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
    end
  end

`ifdef RMGMT_MEM_ALIGN_CHK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  assign in_access    = (state_q == RMGMT_ACCESS);
  assign dbus_ren     = in_access && !wr_q;
  assign dbus_wen     = in_access && wr_q;
  assign dbus_addr    = in_access ? addr_out : '0;
  assign dbus_wdata   = in_access ? wdata_q : '0;
  assign dbus_byte_en = in_access ? DBUS_BYTE_EN_WORD : '0;

  assign mem_load = load_q;
  assign mem_busy = req_mem && (state_q != RMGMT_DONE);

endmodule

// File: tb/tb_rmgmt_mem_bridge.sv
// Directed-vector bench for rmgmt_mem_bridge; cycle N is the interval after the Nth rising edge.
module tb_rmgmt_mem_bridge;
  import rv32i_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_mem, mem_ren, mem_wen;
  word_t       mem_addr, mem_store, mem_load;
  logic        mem_busy, core_dreq, flush;
  word_t       dbus_addr, dbus_wdata;
  logic        dbus_ren, dbus_wen;
  logic [3:0]  dbus_byte_en;
  logic        dbus_busy;
  word_t       dbus_rdata;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rmgmt_mem_bridge dut (
    .CLK(CLK), .RST(RST), .req_mem(req_mem), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_store(mem_store), .mem_load(mem_load), .mem_busy(mem_busy),
    .core_dreq(core_dreq), .flush(flush), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ren(dbus_ren), .dbus_wen(dbus_wen), .dbus_byte_en(dbus_byte_en),
    .dbus_busy(dbus_busy), .dbus_rdata(dbus_rdata), .mem_fault(mem_fault)
  );

  // Advance into the next cycle; inputs are then changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs();
    req_mem = 0; mem_ren = 0; mem_wen = 0; mem_addr = '0; mem_store = '0;
    core_dreq = 0; flush = 0; dbus_busy = 0; dbus_rdata = '0;
  endtask

  task automatic test_reset();
    RST = 1; idle_inputs();
    tick(); tick();
    RST = 0; #1;
    checks++; if (mem_load !== 32'h0) begin errors++; $display("FAIL reset_load got=%h exp=%h", mem_load, 32'h0); end
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
    checks++; if ({dbus_ren, dbus_wen, dbus_byte_en} !== 6'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=0", {dbus_ren, dbus_wen, dbus_byte_en}); end
    checks++; if ({dbus_addr, dbus_wdata} !== 64'h0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {dbus_addr, dbus_wdata}); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", mem_fault); end
  endtask

  task automatic test_read();
    tick();
    req_mem = 1; mem_ren = 1; mem_addr = 32'h100; #1;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rd_busy_c0 got=%b exp=1", mem_busy); end
    checks++; if (dbus_ren !== 1'b0) begin errors++; $display("FAIL rd_ren_c0 got=%b exp=0", dbus_ren); end
    tick();
    dbus_busy = 0; dbus_rdata = 32'hDEADBEEF; #1;
    checks++; if (dbus_ren !== 1'b1 || dbus_wen !== 1'b0) begin errors++; $display("FAIL rd_strobe_c1 got=%b%b exp=10", dbus_ren, dbus_wen); end
    checks++; if (dbus_addr !== 32'h100) begin errors++; $display("FAIL rd_addr_c1 got=%h exp=%h", dbus_addr, 32'h100); end
    checks++; if (dbus_byte_en !== 4'b1111) begin errors++; $display("FAIL rd_byte_en got=%b exp=1111", dbus_byte_en); end
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rd_busy_c1 got=%b exp=1", mem_busy); end
    tick();
    dbus_rdata = 32'h0; #1;
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_c2 got=%b exp=0", mem_busy); end
    checks++; if (mem_load !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_load_c2 got=%h exp=%h", mem_load, 32'hDEADBEEF); end
    checks++; if (dbus_ren !== 1'b0 || dbus_addr !== 32'h0) begin errors++; $display("FAIL rd_bus_c2 got=%b/%h exp=0/0", dbus_ren, dbus_addr); end
    tick();
    idle_inputs(); #1;
    checks++; if (dbus_ren !== 1'b0 || mem_busy !== 1'b0) begin errors++; $display("FAIL rd_idle_c3 got=%b%b exp=00", dbus_ren, mem_busy); end
  endtask

  task automatic test_write_wait();
    tick();
    req_mem = 1; mem_wen = 1; mem_addr = 32'h200; mem_store = 32'h12345678;
    core_dreq = 1; dbus_rdata = 32'h5555AAAA; #1;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_c0 got=%b exp=1", mem_busy); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      core_dreq = (c < 3); #1;
      checks++; if (dbus_wen !== 1'b0 || mem_busy !== 1'b1) begin errors++; $display("FAIL wr_wait_c%0d wen=%b busy=%b exp wen=0 busy=1", c, dbus_wen, mem_busy); end
    end
    tick();
    #1;
    checks++; if (dbus_wen !== 1'b1 || dbus_ren !== 1'b0) begin errors++; $display("FAIL wr_strobe_c4 got=%b%b exp=01", dbus_ren, dbus_wen); end
    checks++; if (dbus_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata got=%h exp=%h", dbus_wdata, 32'h12345678); end
    checks++; if (dbus_addr !== 32'h200) begin errors++; $display("FAIL wr_addr got=%h exp=%h", dbus_addr, 32'h200); end
    tick();
    #1;
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL wr_done_busy got=%b exp=0", mem_busy); end
    checks++; if (mem_load !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_load_kept got=%h exp=%h", mem_load, 32'hDEADBEEF); end
    tick();
    idle_inputs();
  endtask

  task automatic test_bus_stall();
    tick();
    req_mem = 1; mem_ren = 1; mem_addr = 32'h300; dbus_busy = 1; #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      dbus_busy = 1; dbus_rdata = 32'hBAD0_0000 + c; #1;
      checks++; if (mem_busy !== 1'b1 || dbus_ren !== 1'b1) begin errors++; $display("FAIL stall_c%0d busy=%b ren=%b exp 1 1", c, mem_busy, dbus_ren); end
    end
    tick();
    dbus_busy = 0; dbus_rdata = 32'hA5A50001; #1;
    checks++; if (mem_busy !== 1'b1 || dbus_ren !== 1'b1) begin errors++; $display("FAIL stall_c6 busy=%b ren=%b exp 1 1", mem_busy, dbus_ren); end
    tick();
    dbus_rdata = 32'h0; #1;
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL stall_done_busy got=%b exp=0", mem_busy); end
    checks++; if (mem_load !== 32'hA5A50001) begin errors++; $display("FAIL stall_load got=%h exp=%h", mem_load, 32'hA5A50001); end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush_wait();
    tick();
    req_mem = 1; mem_ren = 1; mem_addr = 32'h400; core_dreq = 1; #1;
    tick();
    flush = 1; core_dreq = 0; #1;
    checks++; if (dbus_ren !== 1'b0) begin errors++; $display("FAIL flw_ren_c1 got=%b exp=0", dbus_ren); end
    tick();
    idle_inputs(); #1;
    checks++; if (dbus_ren !== 1'b0 || dbus_addr !== 32'h0) begin errors++; $display("FAIL flw_ren_c2 got=%b/%h exp=0/0", dbus_ren, dbus_addr); end
    tick();
    #1;
    checks++; if (dbus_ren !== 1'b0) begin errors++; $display("FAIL flw_ren_c3 got=%b exp=0", dbus_ren); end
    // flush coincident with a fresh request in IDLE: request must be ignored
    req_mem = 1; mem_ren = 1; mem_addr = 32'h404; flush = 1;
    tick();
    idle_inputs(); #1;
    checks++; if (dbus_ren !== 1'b0) begin errors++; $display("FAIL fli_ren got=%b exp=0", dbus_ren); end
  endtask

  task automatic test_flush_access();
    tick();
    req_mem = 1; mem_ren = 1; mem_addr = 32'h500; dbus_busy = 1; #1;
    tick();
    flush = 1; #1;
    checks++; if (dbus_ren !== 1'b1) begin errors++; $display("FAIL fla_ren_c1 got=%b exp=1", dbus_ren); end
    tick();
    flush = 0; req_mem = 0; dbus_busy = 0; dbus_rdata = 32'h0BADCAFE; #1;
    checks++; if (dbus_ren !== 1'b1 || dbus_addr !== 32'h500) begin errors++; $display("FAIL fla_ren_c2 got=%b/%h exp=1/%h", dbus_ren, dbus_addr, 32'h500); end
    tick();
    idle_inputs(); #1;
    checks++; if (mem_load !== 32'h0BADCAFE) begin errors++; $display("FAIL fla_load got=%h exp=%h", mem_load, 32'h0BADCAFE); end
    checks++; if (dbus_ren !== 1'b0) begin errors++; $display("FAIL fla_done_ren got=%b exp=0", dbus_ren); end
  endtask

  task automatic test_both_strobes();
    tick();
    req_mem = 1; mem_ren = 1; mem_wen = 1; mem_addr = 32'h40; mem_store = 32'hCAFEF00D;
    dbus_rdata = 32'h11111111; #1;
    tick();
    #1;
    checks++; if ({dbus_ren, dbus_wen} !== 2'b01) begin errors++; $display("FAIL both_strobe got=%b%b exp=01", dbus_ren, dbus_wen); end
    checks++; if (dbus_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL both_wdata got=%h exp=%h", dbus_wdata, 32'hCAFEF00D); end
    tick();
    #1;
    checks++; if (mem_load !== 32'h0BADCAFE) begin errors++; $display("FAIL both_load got=%h exp=%h", mem_load, 32'h0BADCAFE); end
    tick();
    idle_inputs();
  endtask

  task automatic test_req_drop_wait();
    tick();
    req_mem = 1; mem_wen = 1; mem_addr = 32'h600; core_dreq = 1; #1;
    tick();
    req_mem = 0; #1;
    tick();
    core_dreq = 0; #1;
    checks++; if (dbus_wen !== 1'b0) begin errors++; $display("FAIL drop_wen_c2 got=%b exp=0", dbus_wen); end
    tick();
    #1;
    checks++; if (dbus_wen !== 1'b0) begin errors++; $display("FAIL drop_wen_c3 got=%b exp=0", dbus_wen); end
    idle_inputs();
  endtask

  task automatic test_reset_access();
    tick();
    req_mem = 1; mem_wen = 1; mem_addr = 32'h700; mem_store = 32'h77777777; dbus_busy = 1; #1;
    tick();
    RST = 1; #1;
    checks++; if (dbus_wen !== 1'b1) begin errors++; $display("FAIL rsta_pre_wen got=%b exp=1", dbus_wen); end
    tick();
    RST = 0; idle_inputs(); dbus_busy = 1; #1;
    checks++; if ({dbus_ren, dbus_wen, dbus_byte_en} !== 6'b0 || {dbus_addr, dbus_wdata} !== 64'h0) begin errors++; $display("FAIL rsta_bus got=%b/%h/%h exp=0", {dbus_ren, dbus_wen, dbus_byte_en}, dbus_addr, dbus_wdata); end
    checks++; if (mem_load !== 32'h0 || mem_busy !== 1'b0 || mem_fault !== 1'b0) begin errors++; $display("FAIL rsta_mem load=%h busy=%b fault=%b exp 0", mem_load, mem_busy, mem_fault); end
    tick();
    dbus_busy = 0; #1;
    checks++; if (dbus_wen !== 1'b0) begin errors++; $display("FAIL rsta_idle_wen got=%b exp=0", dbus_wen); end
  endtask

  task automatic test_align();
    tick();
    req_mem = 1; mem_ren = 1; mem_addr = 32'h103; dbus_rdata = 32'h31313131; #1;
    tick();
    #1;
`ifdef RMGMT_MEM_ALIGN_CHK_EN
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL align_fault_c1 got=%b exp=1", mem_fault); end
    checks++; if (dbus_ren !== 1'b0) begin errors++; $display("FAIL align_ren_c1 got=%b exp=0", dbus_ren); end
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL align_busy_c1 got=%b exp=0", mem_busy); end
    tick();
    req_mem = 0; mem_ren = 0; #1;
    checks++; if (mem_fault !== 1'b0 || dbus_ren !== 1'b0) begin errors++; $display("FAIL align_c2 fault=%b ren=%b exp 0 0", mem_fault, dbus_ren); end
`else
    checks++; if (dbus_addr !== 32'h100) begin errors++; $display("FAIL align_addr got=%h exp=%h", dbus_addr, 32'h100); end
    checks++; if (dbus_ren !== 1'b1 || mem_fault !== 1'b0) begin errors++; $display("FAIL align_ren ren=%b fault=%b exp 1 0", dbus_ren, mem_fault); end
    tick();
    req_mem = 0; mem_ren = 0; #1;
    checks++; if (mem_load !== 32'h31313131) begin errors++; $display("FAIL align_load got=%h exp=%h", mem_load, 32'h31313131); end
`endif
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_bus_stall();
    test_flush_wait();
    test_flush_access();
    test_both_strobes();
    test_req_drop_wait();
    test_reset_access();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmgmt_mem_bridge.md
RMGMT_MEM_BRIDGE -- requirements
Module: rmgmt_mem_bridge

Interface
REQ-001 Params: none; data width is the shared word type (32 bits).
REQ-002 CLK  in  1  sole clock, rising edge.
REQ-003 RST  in  1  reset; synchronous and active-high.
REQ-004 req_mem  in  1  RISC-MGMT extension requests a memory access.
REQ-005 mem_ren / mem_wen  in  1/1  read / write strobe from RISC-MGMT.
REQ-006 mem_addr / mem_store  in  32/32  byte address / write data from RISC-MGMT.
REQ-007 mem_load  out  32  read data returned to RISC-MGMT.
REQ-008 mem_busy  out  1  access not yet complete; RISC-MGMT holds request.
REQ-009 core_dreq  in  1  core execute stage is using the data bus this cycle.
REQ-010 flush  in  1  pipeline flush (exception or redirect).
REQ-011 dbus_addr / dbus_wdata  out  32/32  generic data-bus address / write data.
REQ-012 dbus_ren / dbus_wen  out  1/1  data-bus strobes.
REQ-013 dbus_byte_en  out  4  byte enables, always 4'b1111 (word accesses only).
REQ-014 dbus_busy / dbus_rdata  in  1/32  bus not-done flag / read data.
REQ-015 mem_fault  out  1  misaligned-access pulse (RMGMT_MEM_ALIGN_CHK_EN only).

Function
REQ-016 FSM states: IDLE, WAIT_BUS, ACCESS, DONE.
REQ-017 IDLE: req_mem && (mem_ren||mem_wen) && !flush -> latch addr/data/op; -> WAIT_BUS if core_dreq else ACCESS.
REQ-018 WAIT_BUS: stay while core_dreq; -> ACCESS first cycle core_dreq low.
REQ-019 ACCESS: drive dbus_* from latched values; on dbus_busy low, register dbus_rdata into mem_load; -> DONE.
REQ-020 DONE: mem_busy low for exactly one cycle; -> IDLE next cycle.
REQ-021 mem_busy = req_mem && state != DONE; in IDLE with a valid request it is high that same cycle.
REQ-022 Minimum latency: request in cycle 0, bus strobe in cycle 1, DONE in cycle 2 when dbus_busy low in cycle 1.
REQ-023 dbus_ren/dbus_wen are high only in ACCESS; all dbus outputs are 0 in other states.
REQ-024 mem_ren and mem_wen both high: treated as write; mem_load unchanged.
REQ-025 Write completes: mem_load retains its previous value.
REQ-026 flush in IDLE or WAIT_BUS: drop the request and go to IDLE; no bus strobe is issued.
REQ-027 flush in ACCESS: ignored; the bus transaction completes and the state goes to DONE.
REQ-028 req_mem deasserted in WAIT_BUS: abort to IDLE.
REQ-029 req_mem deasserted in ACCESS: the access still completes.
REQ-030 core_dreq never preempts ACCESS; the core stage stalls on the shared bus-busy.

Reset
REQ-031 RST high at a clock edge: state=IDLE, mem_load=0, latched regs=0, mem_fault=0, all dbus outputs 0.
REQ-032 The effect of REQ-031 is also applied mid-transaction, regardless of dbus_busy.

Configuration
REQ-033 Macro RMGMT_MEM_ALIGN_CHK_EN, when defined:
- Request in IDLE with mem_addr[1:0] != 0 -> no bus access.
- mem_fault pulses high 1 cycle and the state goes to DONE.
REQ-034 RMGMT_MEM_ALIGN_CHK_EN, when undefined:
- mem_fault is tied 0.
- dbus_addr[1:0] is forced to 2'b00.

Structure
REQ-035 State enum rmgmt_mem_state_t lives in rv32i_types_pkg alongside word_t.
REQ-036 Single flat module; no sub-modules.

Verification
REQ-037 Read, bus free, dbus_busy low in cycle 1, addr 0x100, rdata 0xDEADBEEF -> mem_load=0xDEADBEEF and mem_busy low in cycle 2.
REQ-038 Write with core_dreq high 3 cycles, store 0x12345678 @0x200 -> dbus_wen asserted cycle 4, dbus_wdata=0x12345678, mem_load unchanged.
REQ-039 dbus_busy high 5 cycles in ACCESS -> mem_busy high throughout, DONE 1 cycle after busy drops.
REQ-040 flush in WAIT_BUS -> no dbus strobe ever, state IDLE next cycle.
REQ-041 RST asserted in ACCESS -> next cycle all outputs 0, state IDLE.
REQ-042 Align check enabled, read @0x103 -> mem_fault one-cycle pulse, no dbus_ren.
REQ-043 Align check disabled, read @0x103 -> dbus_addr=0x100.
